dpram_dma: RTL and testbench

- Bus initiator for the scalar dual-port RAM request/response protocol. It drives the t_* request channel and consumes the i_* response channel of one RAM port.
- Copies cmd_len 32-bit words from cmd_src to cmd_dst using word reads and writes.
- Sits beside the core and frees it from bulk moves between scalar RAM regions.

---
 rtl/dpram_dma.sv | 207 ++++++++++++++++++++
 tb/tb_dpram_dma.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_dma.sv
// Word-copy DMA initiator for the scalar dual-port RAM request/response protocol.
// Optional constant-fill mode is enabled by defining DPRAM_DMA_FILL_EN.
module dpram_dma #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rstf,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [31:0]          cmd_src,
    input  logic [31:0]          cmd_dst,
    input  logic [LEN_WIDTH-1:0] cmd_len,
`ifdef DPRAM_DMA_FILL_EN
    input  logic                 cmd_fill,
    input  logic [31:0]          cmd_pattern,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 t_valid,
    input  logic                 t_ready,
    output logic                 t_we,
    output logic [1:0]           t_size,
    output logic [31:0]          t_addr,
    output logic [31:0]          t_data,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [31:0]          i_data
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                 state_q, state_d;
    logic [31:0]            src_q, dst_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   rd_issued_q, rd_issued_d;
    logic [LEN_WIDTH-1:0]   wr_issued_q, wr_issued_d;
    logic [LEN_WIDTH-1:0]   wr_acked_q;
    logic                   t_valid_q, t_valid_d, t_we_q, t_we_d;
    logic [31:0]            t_addr_q, t_addr_d, t_data_q, t_data_d;
    logic                   latch;

    logic [31:0]            fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]          fifo_rd_q, fifo_wr_q, head_ptr;
    logic [CW-1:0]          fifo_cnt_q, fifo_cnt_d;
    logic [FIFO_DEPTH-1:0]  tag_mem;
    logic [PW-1:0]          tag_rd_q, tag_wr_q;
    logic [CW-1:0]          tag_cnt_q, tag_cnt_d;
    logic [CW-1:0]          rif_q, rif_d;

    logic accept, wr_pop, tag_pop, resp_read, resp_write, fifo_avail, credit_ok;
    logic fill_mode;
    logic [31:0] fill_pattern;

`ifdef DPRAM_DMA_FILL_EN
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            fill_mode    <= 1'b0;
            fill_pattern <= '0;
        end else if (latch) begin
            fill_mode    <= cmd_fill;
            fill_pattern <= cmd_pattern;
        end
    end
`else
    assign fill_mode    = 1'b0;
    assign fill_pattern = '0;
`endif

    assign accept     = t_valid_q & t_ready;
    assign wr_pop     = accept & t_we_q;
    assign tag_pop    = i_valid & (tag_cnt_q != '0);
    assign resp_read  = tag_pop & ~tag_mem[tag_rd_q];
    assign resp_write = tag_pop & tag_mem[tag_rd_q];
    assign tag_cnt_d  = tag_cnt_q + CW'(accept) - CW'(tag_pop);
    assign fifo_cnt_d = fifo_cnt_q + CW'(resp_read) - CW'(wr_pop);
    assign rif_d      = rif_q + CW'(accept & ~t_we_q) - CW'(resp_read);
    // Data pushed this cycle is not yet visible as the head; it is picked up next cycle.
    assign head_ptr   = fifo_rd_q + PW'(wr_pop);
    assign fifo_avail = (fifo_cnt_q - CW'(wr_pop)) != '0;
    assign credit_ok  = ({1'b0, fifo_cnt_d} + {1'b0, rif_d}) < DEPTH_W;

    always_comb begin
        state_d     = state_q;
        t_valid_d   = t_valid_q;
        t_we_d      = t_we_q;
        t_addr_d    = t_addr_q;
        t_data_d    = t_data_q;
        rd_issued_d = rd_issued_q;
        wr_issued_d = wr_issued_q;
        latch       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    latch       = 1'b1;
                    rd_issued_d = '0;
                    wr_issued_d = '0;
                    state_d     = (cmd_len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (!t_valid_q || t_ready) begin
                    t_valid_d = 1'b0;
                    // Tag queue bounds outstanding requests, reads and writes alike.
                    if (tag_cnt_d < DEPTH_C) begin
                        if (fill_mode) begin
                            if (wr_issued_q < len_q) begin
                                t_valid_d   = 1'b1;
                                t_we_d      = 1'b1;
                                t_addr_d    = dst_q + 32'({wr_issued_q, 2'b00});
                                t_data_d    = fill_pattern;
                                wr_issued_d = wr_issued_q + 1'b1;
                            end
                        end else if (fifo_avail) begin
                            t_valid_d   = 1'b1;
                            t_we_d      = 1'b1;
                            t_addr_d    = dst_q + 32'({wr_issued_q, 2'b00});
                            t_data_d    = fifo_mem[head_ptr];
                            wr_issued_d = wr_issued_q + 1'b1;
                        end else if (rd_issued_q < len_q && credit_ok) begin
                            t_valid_d   = 1'b1;
                            t_we_d      = 1'b0;
                            t_addr_d    = src_q + 32'({rd_issued_q, 2'b00});
                            rd_issued_d = rd_issued_q + 1'b1;
                        end
                    end
                end
                if (wr_acked_q == len_q) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            state_q     <= StIdle;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            rd_issued_q <= '0;
            wr_issued_q <= '0;
            wr_acked_q  <= '0;
            t_valid_q   <= 1'b0;
            t_we_q      <= 1'b0;
            t_addr_q    <= '0;
            t_data_q    <= '0;
            fifo_rd_q   <= '0;
            fifo_wr_q   <= '0;
            fifo_cnt_q  <= '0;
            tag_rd_q    <= '0;
            tag_wr_q    <= '0;
            tag_cnt_q   <= '0;
            rif_q       <= '0;
            tag_mem     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            state_q     <= state_d;
            rd_issued_q <= rd_issued_d;
            wr_issued_q <= wr_issued_d;
            t_valid_q   <= t_valid_d;
            t_we_q      <= t_we_d;
            t_addr_q    <= t_addr_d;
            t_data_q    <= t_data_d;
            fifo_cnt_q  <= fifo_cnt_d;
            tag_cnt_q   <= tag_cnt_d;
            rif_q       <= rif_d;
            if (latch) begin
                src_q      <= cmd_src & ~32'h3;
                dst_q      <= cmd_dst & ~32'h3;
                len_q      <= cmd_len;
                wr_acked_q <= '0;
            end else if (resp_write) begin
                wr_acked_q <= wr_acked_q + 1'b1;
            end
            if (accept) begin
                tag_mem[tag_wr_q] <= t_we_q;
                tag_wr_q          <= tag_wr_q + 1'b1;
            end
            if (tag_pop) tag_rd_q <= tag_rd_q + 1'b1;
            if (resp_read) begin
                fifo_mem[fifo_wr_q] <= i_data;
                fifo_wr_q           <= fifo_wr_q + 1'b1;
            end
            if (wr_pop) fifo_rd_q <= fifo_rd_q + 1'b1;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign t_valid   = t_valid_q;
    assign t_we      = t_we_q;
    assign t_addr    = t_addr_q;
    assign t_data    = t_data_q;
    assign t_size    = 2'b10;
    assign i_ready   = 1'b1;

    // A response with nothing outstanding is a responder protocol violation.
    assert property (@(posedge clk) disable iff (!rstf) i_valid |-> (tag_cnt_q != '0));

endmodule

// File: tb/tb_dpram_dma.sv
// Bench for dpram_dma: RAM responder with variable latency/backpressure and an
// order-level copy model checked every cycle.
module tb_dpram_dma;

    localparam int DEPTH = 4;

    logic        clk, rstf, cmd_valid, cmd_ready;
    logic [31:0] cmd_src, cmd_dst;
    logic [15:0] cmd_len;
    logic        busy, done, t_valid, t_ready, t_we, i_valid, i_ready;
    logic [1:0]  t_size;
    logic [31:0] t_addr, t_data, i_data;
`ifdef DPRAM_DMA_FILL_EN
    logic        cmd_fill;
    logic [31:0] cmd_pattern;
`endif

    dpram_dma #(.FIFO_DEPTH(DEPTH), .LEN_WIDTH(16)) dut (
        .clk(clk), .rstf(rstf), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
`ifdef DPRAM_DMA_FILL_EN
        .cmd_fill(cmd_fill), .cmd_pattern(cmd_pattern),
`endif
        .busy(busy), .done(done), .t_valid(t_valid), .t_ready(t_ready), .t_we(t_we),
        .t_size(t_size), .t_addr(t_addr), .t_data(t_data), .i_valid(i_valid),
        .i_ready(i_ready), .i_data(i_data)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] mem    [0:1023];
    logic [31:0] golden [0:63];
    logic [31:0] m_src, m_dst;
    int  m_len;
    bit  m_fill;
    int  nrd, nwr, nacc, nresp, ndone, max_rw, nstall;
    int  lat = 1;
    bit  rnd_ready = 0;
    int  cyc = 0;
    int  due_q[$];
    logic [31:0] dat_q[$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Responder: presents queued responses after each rising edge, drives t_ready.
    initial begin
        i_valid = 0;
        i_data  = 0;
        t_ready = 1;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rstf) begin
                due_q.delete();
                dat_q.delete();
                i_valid = 0;
            end else if (due_q.size() > 0 && due_q[0] == cyc) begin
                i_valid = 1;
                i_data  = dat_q[0];
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end else begin
                i_valid = 0;
            end
            t_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Responder: performs accepted requests on the RAM array.
    initial begin
        forever begin
            @(negedge clk);
            if (rstf && t_valid && t_ready) begin
                if (t_we) begin
                    mem[t_addr[11:2]] = t_data;
                    dat_q.push_back(32'h0);
                end else begin
                    dat_q.push_back(mem[t_addr[11:2]]);
                end
                due_q.push_back(cyc + lat);
            end
        end
    end

    // Compare process: request order/addresses/data, stability and credit limits.
    initial begin
        bit prev_stall;
        logic prev_we;
        logic [31:0] prev_addr, prev_data;
        prev_stall = 0;
        forever begin
            @(negedge clk);
            if (!rstf) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", t_valid, 1);
                    check("stall_we", t_we, prev_we);
                    check("stall_addr", t_addr, prev_addr);
                    check("stall_data", t_data, prev_data);
                end
                prev_stall = 0;
                if (busy) begin
                    check("outstanding_le_depth", (nacc - nresp) <= DEPTH, 1);
                    check("read_credit_le_depth", (nrd - nwr) <= DEPTH, 1);
                end
                if (t_valid && t_ready) begin
                    check("t_size_word", t_size, 2'b10);
                    if (t_we) begin
                        check("wr_count_bound", nwr < m_len, 1);
                        check("wr_addr", t_addr, m_dst + 32'(4 * nwr));
                        check("wr_data", t_data, golden[nwr % 64]);
                        nwr++;
                    end else begin
                        check("rd_count_bound", nrd < m_len, 1);
                        check("rd_addr", t_addr, m_src + 32'(4 * nrd));
                        nrd++;
                    end
                    nacc++;
                    if (nrd - nwr > max_rw) max_rw = nrd - nwr;
                end
                if (t_valid && !t_ready) begin
                    prev_stall = 1;
                    prev_we    = t_we;
                    prev_addr  = t_addr;
                    prev_data  = t_data;
                    nstall++;
                end
                if (i_valid) nresp++;
                if (done) ndone++;
            end
        end
    end

    task automatic preload(input logic [31:0] base, input int n, input logic [31:0] seed);
        logic [9:0] idx;
        idx = base[11:2];
        for (int k = 0; k < n; k++) mem[idx + 10'(k)] = seed + 32'(k) * 32'h01030507;
    endtask

    task automatic run_cmd(input logic [31:0] src, input logic [31:0] dst, input int len,
                           input bit fill, input logic [31:0] pat);
        logic [9:0] idx;
        m_src = src & ~32'h3;
        m_dst = dst & ~32'h3;
        m_len = len;
        m_fill = fill;
        nrd = 0; nwr = 0; nacc = 0; nresp = 0; ndone = 0; max_rw = 0; nstall = 0;
        idx = m_src[11:2];
        for (int k = 0; k < len; k++) golden[k] = fill ? pat : mem[idx + 10'(k)];
        @(posedge clk);
        #2;
        cmd_valid = 1;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_len   = 16'(len);
`ifdef DPRAM_DMA_FILL_EN
        cmd_fill    = fill;
        cmd_pattern = pat;
`endif
        @(negedge clk);
        check("cmd_ready_before_cmd", cmd_ready, 1);
        @(posedge clk);
        #2;
        cmd_valid = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check({name, "_done_seen"}, seen, 1);
        if (seen) begin
            check({name, "_busy_in_done"}, busy, 1);
            @(negedge clk);
            check({name, "_done_one_cycle"}, done, 0);
            check({name, "_ready_after"}, cmd_ready, 1);
            check({name, "_busy_after"}, busy, 0);
        end
    endtask

    task automatic verify(input string name);
        logic [9:0] idx;
        idx = m_dst[11:2];
        for (int k = 0; k < m_len; k++) check({name, "_dst_word"}, mem[idx + 10'(k)], golden[k]);
        check({name, "_writes"}, nwr, m_len);
        check({name, "_reads"}, nrd, m_fill ? 0 : m_len);
        check({name, "_done_pulses"}, ndone, 1);
    endtask

    initial begin
        bit hit;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rstf = 0; cmd_valid = 0; cmd_src = 0; cmd_dst = 0; cmd_len = 0;
`ifdef DPRAM_DMA_FILL_EN
        cmd_fill = 0; cmd_pattern = 0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstf = 1;
        @(negedge clk);
        check("rst_t_valid", t_valid, 0);
        check("rst_t_we", t_we, 0);
        check("rst_t_addr", t_addr, 0);
        check("rst_t_data", t_data, 0);
        check("rst_t_size", t_size, 2'b10);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_i_ready", i_ready, 1);

        // Basic copy of four known words.
        mem[0] = 32'h11111111; mem[1] = 32'h22222222;
        mem[2] = 32'h33333333; mem[3] = 32'h44444444;
        run_cmd(32'h000, 32'h100, 4, 0, 0);
        wait_done("t1", 200);
        verify("t1");
        check("t1_accepted", nacc, 8);
        check("t1_word0", mem[64], 32'h11111111);
        check("t1_word3", mem[67], 32'h44444444);

        // Zero-length command: done the cycle after the handshake edge, no requests.
        run_cmd(32'h010, 32'h020, 0, 0, 0);
        @(negedge clk);
        check("t2_done", done, 1);
        check("t2_no_valid", t_valid, 0);
        @(negedge clk);
        check("t2_done_low", done, 0);
        check("t2_ready", cmd_ready, 1);
        check("t2_accepted", nacc, 0);

        // Random backpressure.
        preload(32'h300, 16, 32'hA5A50000);
        rnd_ready = 1;
        run_cmd(32'h300, 32'h400, 16, 0, 0);
        wait_done("t3", 2000);
        rnd_ready = 0;
        verify("t3");
        check("t3_stalls_seen", nstall > 0, 1);

        // Three-cycle responder latency: read issue must reach and hold at the credit limit.
        preload(32'h500, 8, 32'h5A000000);
        lat = 3;
        run_cmd(32'h503, 32'h600, 8, 0, 0);
        wait_done("t4", 1000);
        verify("t4");
        check("t4_max_credit", max_rw, 4);
        lat = 1;

        // Asynchronous reset mid-copy, then a fresh copy.
        preload(32'h700, 16, 32'h77000000);
        run_cmd(32'h700, 32'h800, 16, 0, 0);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (nacc >= 5) hit = 1;
        end
        check("t5_reached_5", hit, 1);
        rstf = 0;
        #1;
        check("t5_async_valid", t_valid, 0);
        check("t5_async_busy", busy, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstf = 1;
        @(negedge clk);
        check("t5_ready_after", cmd_ready, 1);
        check("t5_no_valid", t_valid, 0);
        preload(32'h900, 2, 32'h99000000);
        run_cmd(32'h900, 32'hA00, 2, 0, 0);
        wait_done("t5", 200);
        verify("t5");
        check("t5_accepted", nacc, 4);

`ifdef DPRAM_DMA_FILL_EN
        run_cmd(32'h000, 32'h200, 3, 1, 32'hDEADBEEF);
        wait_done("t6", 200);
        verify("t6");
        check("t6_word0", mem[128], 32'hDEADBEEF);
        check("t6_word2", mem[130], 32'hDEADBEEF);
        check("t6_accepted", nacc, 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
